acondicionador_entradas: RTL and testbench

Input-conditioning stage directly upstream of the two-input pattern-detecting Moore FSM. It takes two raw, asynchronous, bouncy inputs (switches or buttons), synchronises each into the clk domain, and debounces each one independently. It drives clean levels A and B that feed straight into the FSM's A/B inputs, plus one-cycle change strobes and a debug state bus.

---
 rtl/acondicionador_entradas_pkg.sv | 17 +
 rtl/acondicionador_entradas_antirrebote_canal.sv | 104 ++++++++++
 rtl/acondicionador_entradas.sv | 41 ++++
 tb/tb_acondicionador_entradas.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/acondicionador_entradas_pkg.sv
// Shared definitions for the input-conditioning stage: per-channel
// debounce state encodings, default debounce length and a level decoder.
package acondicionador_entradas_pkg;

  localparam logic [1:0] ST_LO   = 2'b00;
  localparam logic [1:0] WAIT_HI = 2'b01;
  localparam logic [1:0] ST_HI   = 2'b10;
  localparam logic [1:0] WAIT_LO = 2'b11;

  localparam int N_DEB_DEF = 16;

  // The encoding puts the Moore output level in bit 1 (ST_HI, WAIT_LO).
  function automatic logic nivel_de(input logic [1:0] st);
    return st[1];
  endfunction

endpackage

// File: rtl/acondicionador_entradas_antirrebote_canal.sv
// One debounce channel: 2-flop synchroniser followed by a 4-state FSM
// with a hold counter. The output level and change strobe are registered
// together with the state.
module antirrebote_canal
  import acondicionador_entradas_pkg::*;
#(
  parameter int N_DEB = N_DEB_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw,
  output logic       level,
  output logic       chg,
  output logic [1:0] state
);

  localparam int W_CNT = $clog2(N_DEB + 1);
  localparam logic [W_CNT-1:0] CNT_UNO = W_CNT'(1);
  localparam logic [W_CNT-1:0] CNT_FIN = W_CNT'(N_DEB - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [1:0]       st_q, st_d;
  logic [W_CNT-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             chg_q, chg_d;

  // Next-state logic: synchroniser shift, debounce FSM and hold counter.
  always_comb begin
    s1_d  = raw;
    s2_d  = s1_q;
    st_d  = st_q;
    cnt_d = cnt_q;
    chg_d = 1'b0;
    case (st_q)
      ST_LO: begin
        if (s2_q) begin
          st_d  = WAIT_HI;
          cnt_d = CNT_UNO;
        end
      end
      WAIT_HI: begin
        if (!s2_q) begin
          st_d  = ST_LO;
          cnt_d = '0;
        end else if (cnt_q == CNT_FIN) begin
          st_d  = ST_HI;
          cnt_d = '0;
          chg_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_UNO;
        end
      end
      ST_HI: begin
        if (!s2_q) begin
          st_d  = WAIT_LO;
          cnt_d = CNT_UNO;
        end
      end
      WAIT_LO: begin
        if (s2_q) begin
          st_d  = ST_HI;
          cnt_d = '0;
        end else if (cnt_q == CNT_FIN) begin
          st_d  = ST_LO;
          cnt_d = '0;
          chg_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_UNO;
        end
      end
      default: begin
        st_d  = ST_LO;
        cnt_d = '0;
      end
    endcase
    // Level follows the next state so it updates on the same edge.
    level_d = nivel_de(st_d);
  end

  // State registers; reset aborts any pending transition silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      st_q    <= ST_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      chg_q   <= chg_d;
    end
  end

  assign level = level_q;
  assign chg   = chg_q;
  assign state = st_q;

endmodule

// File: rtl/acondicionador_entradas.sv
// Input conditioning for the A/B pattern FSM: two independent debounce
// channels and a combined debug state bus.
module acondicionador_entradas
  import acondicionador_entradas_pkg::*;
#(
  parameter int N_DEB = N_DEB_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_raw,
  input  logic       b_raw,
  output logic       A,
  output logic       B,
  output logic       a_chg,
  output logic       b_chg,
  output logic [3:0] estado_depurado
);

  logic [1:0] st_a, st_b;

  antirrebote_canal #(.N_DEB(N_DEB)) u_canal_a (
    .clk   (clk),
    .rst   (rst),
    .raw   (a_raw),
    .level (A),
    .chg   (a_chg),
    .state (st_a)
  );

  antirrebote_canal #(.N_DEB(N_DEB)) u_canal_b (
    .clk   (clk),
    .rst   (rst),
    .raw   (b_raw),
    .level (B),
    .chg   (b_chg),
    .state (st_b)
  );

  assign estado_depurado = {st_b, st_a};

endmodule

// File: tb/tb_acondicionador_entradas.sv
// Directed bench for acondicionador_entradas with N_DEB=4.
module tb_acondicionador_entradas;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_raw, b_raw;
  logic       A, B, a_chg, b_chg;
  logic [3:0] estado_depurado;

  int checks   = 0;
  int failures = 0;
  int a_pulses = 0;
  int b_pulses = 0;
  int snap;
  logic [1:0] seq_exp [5];

  acondicionador_entradas #(.N_DEB(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .a_raw           (a_raw),
    .b_raw           (b_raw),
    .A               (A),
    .B               (B),
    .a_chg           (a_chg),
    .b_chg           (b_chg),
    .estado_depurado (estado_depurado)
  );

  always #5 clk = ~clk;

  // Strobe pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (a_chg) a_pulses++;
    if (b_chg) b_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    seq_exp[0] = 2'b00; seq_exp[1] = 2'b01; seq_exp[2] = 2'b01;
    seq_exp[3] = 2'b01; seq_exp[4] = 2'b10;

    // Reset held 3 cycles with both raw inputs high
    rst = 1'b1; a_raw = 1'b1; b_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_A", A, 0);
      chk("rst_B", B, 0);
      chk("rst_chg", {a_chg, b_chg}, 0);
      chk("rst_estado", estado_depurado, 4'b0000);
    end
    rst = 1'b0;
    ticks(5);
    chk("post_rst_A_e5", A, 0);
    tick();
    chk("post_rst_A_e6", A, 1);
    chk("post_rst_achg_e6", a_chg, 1);
    chk("post_rst_estado_e6", estado_depurado, 4'b1010);
    tick();
    chk("post_rst_achg_e7", a_chg, 0);
    chk("post_rst_apulses", a_pulses, 1);

    // Fall back to A=0 for the clean-rise test
    a_raw = 1'b0;
    ticks(7);
    chk("fall_A", A, 0);
    chk("fall_apulses", a_pulses, 2);

    // Clean rise: capture at edge k, state sequence on k+1..k+5
    a_raw = 1'b1;
    tick();
    chk("rise_st_k", estado_depurado[1:0], 2'b00);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rise_st_k%0d", i + 1), estado_depurado[1:0], seq_exp[i]);
      chk($sformatf("rise_A_k%0d", i + 1), A, (i == 4) ? 1 : 0);
    end
    chk("rise_achg_k5", a_chg, 1);
    tick();
    chk("rise_achg_k6", a_chg, 0);
    chk("rise_apulses", a_pulses, 3);

    // Return to A=0, then a 3-cycle glitch must be rejected
    a_raw = 1'b0;
    ticks(7);
    snap = a_pulses;
    a_raw = 1'b1;
    ticks(3);
    a_raw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("bounce_A_%0d", i), A, 0);
    end
    chk("bounce_st", estado_depurado[1:0], 2'b00);
    chk("bounce_apulses", a_pulses, snap);

    // Bounce 1,0,1,0 then settle high
    a_raw = 1'b1; tick();
    a_raw = 1'b0; tick();
    a_raw = 1'b1; tick();
    a_raw = 1'b0; tick();
    a_raw = 1'b1; tick();
    ticks(4);
    chk("settle_A_k4", A, 0);
    tick();
    chk("settle_A_k5", A, 1);
    chk("settle_achg_k5", a_chg, 1);
    ticks(3);
    chk("settle_apulses", a_pulses, snap + 1);

    // Simultaneous: A 0->1 and B 1->0
    a_raw = 1'b0;
    ticks(7);
    chk("simul_pre_A", A, 0);
    chk("simul_pre_B", B, 1);
    a_raw = 1'b1; b_raw = 1'b0;
    ticks(5);
    chk("simul_AB_k4", {A, B}, 2'b01);
    tick();
    chk("simul_AB_k5", {A, B}, 2'b10);
    chk("simul_chg_k5", {a_chg, b_chg}, 2'b11);
    chk("simul_estado_k5", estado_depurado, 4'b0010);
    tick();
    chk("simul_chg_k6", {a_chg, b_chg}, 2'b00);

    // Reset mid-debounce
    a_raw = 1'b0;
    ticks(7);
    snap = a_pulses;
    a_raw = 1'b1;
    ticks(3);
    chk("midrst_st_wait", estado_depurado[1:0], 2'b01);
    rst = 1'b1;
    tick();
    chk("midrst_st", estado_depurado, 4'b0000);
    chk("midrst_A", A, 0);
    chk("midrst_achg", a_chg, 0);
    tick();
    rst = 1'b0;
    ticks(5);
    chk("midrst_A_e5", A, 0);
    chk("midrst_apulses_e5", a_pulses, snap);
    tick();
    chk("midrst_A_e6", A, 1);
    chk("midrst_achg_e6", a_chg, 1);
    tick();
    chk("midrst_apulses_end", a_pulses, snap + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
